activity_scheduler: RTL and testbench
=====================================

ACTIVITY_SCHEDULER -- requirements
Module: activity_scheduler

Interface
REQ-001: Parameters: none; the 256-entry size (16 words x 16 bits) is fixed by package constants.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: mark_valid  input  1  request to mark neuron mark_id active this cycle.
REQ-005: mark_id  input  8  neuron index; [7:4] word, [3:0] bit.
REQ-006: clear_all  input  1  drop all pending activity and any held output.
REQ-007: out_valid  output  1  out_id holds an active neuron index.
REQ-008: out_id  output  8  index of next neuron to process.
REQ-009: out_ready  input  1  consumer accepts out_id when out_valid && out_ready.
REQ-010: pending  output  9  number of set bits in the bitmap, excluding the held output.
REQ-011: idle  output  1  high when pending == 0 and out_valid == 0.

Function
REQ-012: Storage SHALL be 16 x 16-bit word registers plus a 16-bit summary register; summary[w] SHALL equal |word[w] after every update.
REQ-013: Selection SHALL be combinational: word index = lowest set bit of summary; bit index = lowest set bit of word[selected]; candidate id = {word, bit}.
REQ-014: Output register is "free" when out_valid == 0, or out_valid && out_ready.
REQ-015: When free and summary != 0, the candidate SHALL load into out_id, out_valid SHALL be 1 next cycle, and the candidate bit SHALL clear in the same edge.
REQ-016: When free and summary == 0, out_valid SHALL go 0 next cycle.
REQ-017: While out_valid && !out_ready, out_id and out_valid SHALL hold stable.
REQ-018: Throughput SHALL be one id per cycle with out_ready held high.
REQ-019: Latency SHALL be: mark at edge t sets the bit at t+1; out_valid rises at t+2 if the output was free and no lower index was pending.
REQ-020: Marking an already-set bit SHALL be a no-op; pending unchanged.
REQ-021: A mark and a pop of the same id in one cycle SHALL leave the bit set: the mark wins, pending is unchanged, and the id is emitted again later.
REQ-022: Marks of other ids in a pop cycle SHALL apply normally; the pop uses the pre-edge bitmap.
REQ-023: Marking the id currently held in out_id SHALL set its bitmap bit, so the id is re-emitted.
REQ-024: pending SHALL update by +1 per newly set bit and -1 per pop, net in the same cycle; range 0..256, no wrap.
REQ-025: clear_all SHALL zero the bitmap, summary, pending and out_valid next cycle; it overrides mark_valid and pop in the same cycle.
REQ-026: Emission order SHALL be lowest index first among bits set at selection time; later lower-index marks may overtake earlier higher ones.

Reset
REQ-027: reset SHALL force all words, summary, out_valid=0, out_id=0 and pending=0; idle=1 the cycle after.
REQ-028: reset SHALL override clear_all, mark_valid and out_ready; mid-stream reset discards all held and pending ids.

Structure
REQ-029: The shared package SHALL hold NUM_WORDS=16, WORD_BITS=16, ID_W=8, PEND_W=9 and the neuron-id typedef.
REQ-030: The block SHALL instantiate the existing 16-bit find-set-bit priority encoder twice: once on summary, once on the selected word.
REQ-031: State SHALL be encoded implicitly as out_valid x (summary != 0); no separate FSM register.

Verification
REQ-032: Reset, then mark 0x25 -> out_valid at t+2, out_id=0x25; pending goes 1 then 0.
REQ-033: Mark 0xF0, 0x03, 0x41 on consecutive cycles, out_ready=1 -> first out_id=0xF0, then 0x03, then 0x41; idle afterwards.
REQ-034: Set all 256 bits, out_ready=1 -> ids 0x00..0xFF in order, one per cycle; pending 256 -> 0.
REQ-035: out_ready=0 with 0x10 held, mark 0x10 and 0x05 -> out_id stays 0x10; after release, 0x05 then 0x10.
REQ-036: Mark 0x22 in the same cycle 0x22 is popped -> bit stays set, pending unchanged, 0x22 emitted again.
REQ-037: clear_all with mark_valid (0x07) and 40 pending -> next cycle pending=0, out_valid=0, 0x07 never emitted; repeat with reset mid-burst -> same result.

Source files
------------

// File: rtl/activity_scheduler_pkg.sv
// activity_scheduler_pkg
//   Shared constants and types for the activity scheduler: the bitmap is
//   NUM_WORDS words of WORD_BITS bits, a neuron id is {word, bit}.
package activity_scheduler_pkg;

    localparam int NUM_WORDS = 16;
    localparam int WORD_BITS = 16;
    localparam int ID_W      = 8;
    localparam int PEND_W    = 9;   // holds 0..256
    localparam int IDX_W     = 4;   // index width of one find-set-bit stage

    typedef logic [ID_W-1:0] neuron_id_t;

endpackage

// File: rtl/activity_scheduler_fsb.sv
// activity_scheduler_fsb
//   16-bit find-set-bit priority encoder: returns the index of the lowest
//   set bit of vec_i.
//   Ports:
//     vec_i  in  16  vector to search
//     idx_o  out 4   index of lowest set bit (0 when vec_i == 0)
//     any_o  out 1   vec_i has at least one set bit
module activity_scheduler_fsb
    import activity_scheduler_pkg::*;
(
    input  logic [WORD_BITS-1:0] vec_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    always_comb begin
        idx_o = '0;
        // Scan downward so the lowest set bit is written last and wins.
        for (int i = WORD_BITS - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
        any_o = |vec_i;
    end

endmodule

// File: rtl/activity_scheduler.sv
// activity_scheduler
//   256-entry activity bitmap feeding a one-deep output register. Marked
//   neuron ids are emitted lowest-index-first, one per cycle while the
//   consumer is ready.
//   Ports:
//     clk         in  1  clock
//     reset       in  1  synchronous active-high reset
//     mark_valid  in  1  mark neuron mark_id active
//     mark_id     in  8  neuron id, [7:4] word, [3:0] bit
//     clear_all   in  1  drop all pending activity and the held output
//     out_valid   out 1  out_id holds an active neuron
//     out_id      out 8  next neuron to process
//     out_ready   in  1  consumer accepts out_id
//     pending     out 9  set bits in the bitmap (held output excluded)
//     idle        out 1  nothing pending and nothing held
module activity_scheduler
    import activity_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mark_valid,
    input  logic [ID_W-1:0]   mark_id,
    input  logic              clear_all,
    output logic              out_valid,
    output logic [ID_W-1:0]   out_id,
    input  logic              out_ready,
    output logic [PEND_W-1:0] pending,
    output logic              idle
);

    logic [NUM_WORDS-1:0][WORD_BITS-1:0] words_q, words_d;
    logic [NUM_WORDS-1:0]                summary_q, summary_d;
    logic                                out_valid_q, out_valid_d;
    neuron_id_t                          out_id_q, out_id_d;
    logic [PEND_W-1:0]                   pending_q, pending_d;

    logic [IDX_W-1:0] sel_word, sel_bit;
    logic             word_any, bit_any, cand_any;
    neuron_id_t       cand_id;
    logic             free, load, mark_was_set, mark_on_cand, inc, dec;

    // Two-level selection: lowest non-empty word, then lowest bit in it.
    activity_scheduler_fsb u_word_sel (
        .vec_i (summary_q),
        .idx_o (sel_word),
        .any_o (word_any)
    );

    activity_scheduler_fsb u_bit_sel (
        .vec_i (words_q[sel_word]),
        .idx_o (sel_bit),
        .any_o (bit_any)
    );

    always_comb begin
        cand_any     = word_any & bit_any;
        cand_id      = {sel_word, sel_bit};
        free         = !out_valid_q || out_ready;
        load         = free && cand_any;
        mark_was_set = words_q[mark_id[7:4]][mark_id[3:0]];
        // A mark landing on the bit being popped keeps it set, so the pop
        // and the mark cancel in the pending count.
        mark_on_cand = mark_valid && load && (mark_id == cand_id);
        inc          = mark_valid && !mark_was_set;
        dec          = load && !mark_on_cand;

        words_d = words_q;
        if (load)       words_d[sel_word][sel_bit] = 1'b0;
        if (mark_valid) words_d[mark_id[7:4]][mark_id[3:0]] = 1'b1;

        pending_d = pending_q + PEND_W'(inc) - PEND_W'(dec);

        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        if (free) begin
            out_valid_d = cand_any;
            if (cand_any) out_id_d = cand_id;
        end

        if (clear_all) begin
            words_d     = '0;
            pending_d   = '0;
            out_valid_d = 1'b0;
        end

        for (int w = 0; w < NUM_WORDS; w++) summary_d[w] = |words_d[w];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            words_q     <= '0;
            summary_q   <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            pending_q   <= '0;
        end else begin
            words_q     <= words_d;
            summary_q   <= summary_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            pending_q   <= pending_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign pending   = pending_q;
    assign idle      = (pending_q == '0) && !out_valid_q;

endmodule

// File: tb/tb_activity_scheduler.sv
module tb_activity_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       mark_valid;
    logic [7:0] mark_id;
    logic       clear_all;
    logic       out_valid;
    logic [7:0] out_id;
    logic       out_ready;
    logic [8:0] pending;
    logic       idle;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    activity_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .mark_valid (mark_valid),
        .mark_id    (mark_id),
        .clear_all  (clear_all),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .pending    (pending),
        .idle       (idle)
    );

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark(input logic [7:0] id);
        mark_valid = 1'b1;
        mark_id    = id;
        tick();
        mark_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mark_valid = 1'b0; mark_id = 8'h00; clear_all = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_id !== 8'h00) begin errs++; $display("FAIL reset_id got=%h exp=00", out_id); end
        checks++; if (pending !== 9'd0) begin errs++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        checks++; if (idle !== 1'b1) begin errs++; $display("FAIL reset_idle got=%0b exp=1", idle); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        mark(8'h25);
        checks++; if (pending !== 9'd1) begin errs++; $display("FAIL single_pend1 got=%0d exp=1", pending); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_early got=%0b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 8'h25) begin errs++; $display("FAIL single_out got=%0b/%h exp=1/25", out_valid, out_id); end
        checks++; if (pending !== 9'd0) begin errs++; $display("FAIL single_pend0 got=%0d exp=0", pending); end
        checks++; if (idle !== 1'b0) begin errs++; $display("FAIL single_busy got=%0b exp=0", idle); end
        tick();
        checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errs++; $display("FAIL single_done got=%0b/%0b exp=0/1", out_valid, idle); end
    endtask

    task automatic test_order();
        logic [7:0] exp_ids [3];
        exp_ids[0] = 8'hF0; exp_ids[1] = 8'h03; exp_ids[2] = 8'h41;
        out_ready = 1'b1;
        mark(8'hF0);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL order_early got=%0b exp=0", out_valid); end
        mark(8'h03);
        checks++; if (out_valid !== 1'b1 || out_id !== exp_ids[0]) begin errs++; $display("FAIL order_0 got=%0b/%h exp=1/%h", out_valid, out_id, exp_ids[0]); end
        mark(8'h41);
        checks++; if (out_valid !== 1'b1 || out_id !== exp_ids[1]) begin errs++; $display("FAIL order_1 got=%0b/%h exp=1/%h", out_valid, out_id, exp_ids[1]); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== exp_ids[2]) begin errs++; $display("FAIL order_2 got=%0b/%h exp=1/%h", out_valid, out_id, exp_ids[2]); end
        tick();
        checks++; if (idle !== 1'b1) begin errs++; $display("FAIL order_idle got=%0b exp=1", idle); end
    endtask

    task automatic test_all256();
        int bad = 0;
        out_ready = 1'b0;
        mark(8'h00);
        tick();   // 0x00 now held in the output register
        for (int i = 0; i < 256; i++) mark(8'(i));
        checks++; if (pending !== 9'd256) begin errs++; $display("FAIL all_full got=%0d exp=256", pending); end
        checks++; if (out_valid !== 1'b1 || out_id !== 8'h00) begin errs++; $display("FAIL all_held got=%0b/%h exp=1/00", out_valid, out_id); end
        out_ready = 1'b1;
        for (int j = 1; j <= 256; j++) begin
            tick();
            if (bad == 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== 8'(j - 1) || pending !== 9'(256 - j)) begin
                    errs++; bad = 1;
                    $display("FAIL all_stream step=%0d got=%0b/%h/%0d exp=1/%h/%0d", j, out_valid, out_id, pending, 8'(j - 1), 256 - j);
                end
            end
        end
        tick();
        checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errs++; $display("FAIL all_done got=%0b/%0b exp=0/1", out_valid, idle); end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        mark(8'h10);
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 8'h10) begin errs++; $display("FAIL hold_load got=%0b/%h exp=1/10", out_valid, out_id); end
        mark(8'h10);
        mark(8'h05);
        checks++; if (out_valid !== 1'b1 || out_id !== 8'h10) begin errs++; $display("FAIL hold_stable got=%0b/%h exp=1/10", out_valid, out_id); end
        checks++; if (pending !== 9'd2) begin errs++; $display("FAIL hold_pend got=%0d exp=2", pending); end
        mark(8'h05);   // already set: no change
        checks++; if (pending !== 9'd2) begin errs++; $display("FAIL hold_dup got=%0d exp=2", pending); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_id !== 8'h05 || pending !== 9'd1) begin errs++; $display("FAIL hold_rel0 got=%h/%0d exp=05/1", out_id, pending); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 8'h10 || pending !== 9'd0) begin errs++; $display("FAIL hold_rel1 got=%0b/%h/%0d exp=1/10/0", out_valid, out_id, pending); end
        tick();
        checks++; if (idle !== 1'b1) begin errs++; $display("FAIL hold_idle got=%0b exp=1", idle); end
    endtask

    task automatic test_same_pop();
        out_ready = 1'b1;
        mark(8'h22);
        mark(8'h22);   // 0x22 is the candidate being popped at this edge
        checks++; if (out_valid !== 1'b1 || out_id !== 8'h22) begin errs++; $display("FAIL same_out got=%0b/%h exp=1/22", out_valid, out_id); end
        checks++; if (pending !== 9'd1) begin errs++; $display("FAIL same_pend got=%0d exp=1", pending); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 8'h22 || pending !== 9'd0) begin errs++; $display("FAIL same_again got=%0b/%h/%0d exp=1/22/0", out_valid, out_id, pending); end
        tick();
        checks++; if (idle !== 1'b1) begin errs++; $display("FAIL same_idle got=%0b exp=1", idle); end
    endtask

    task automatic test_clear();
        int seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 41; i++) mark(8'(8'h40 + i));
        checks++; if (pending !== 9'd40) begin errs++; $display("FAIL clr_pend40 got=%0d exp=40", pending); end
        clear_all = 1'b1; mark_valid = 1'b1; mark_id = 8'h07; out_ready = 1'b1;
        tick();
        clear_all = 1'b0; mark_valid = 1'b0;
        checks++; if (pending !== 9'd0 || out_valid !== 1'b0 || idle !== 1'b1) begin errs++; $display("FAIL clr_now got=%0d/%0b/%0b exp=0/0/1", pending, out_valid, idle); end
        for (int k = 0; k < 6; k++) begin tick(); if (out_valid) seen++; end
        checks++; if (seen !== 0) begin errs++; $display("FAIL clr_leak got=%0d exp=0", seen); end

        // Same again with reset arriving mid-burst.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) mark(8'(8'hA0 + i));
        reset = 1'b1; mark_valid = 1'b1; mark_id = 8'h07; clear_all = 1'b1;
        tick();
        reset = 1'b0; mark_valid = 1'b0; clear_all = 1'b0;
        checks++; if (pending !== 9'd0 || out_valid !== 1'b0 || out_id !== 8'h00) begin errs++; $display("FAIL rst_now got=%0d/%0b/%h exp=0/0/00", pending, out_valid, out_id); end
        seen = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (out_valid) seen++; end
        checks++; if (seen !== 0 || idle !== 1'b1) begin errs++; $display("FAIL rst_leak got=%0d/%0b exp=0/1", seen, idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_all256();
        test_hold();
        test_same_pop();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
